// File: rtl/sign_ext_if.sv
// Bus bundle for the immediate extender: operand/mode in, combinational and registered results out.
// neg_count is present only when SIGNEXT_NEGCOUNT_EN is defined.
interface sign_ext_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
);
    logic [IN_W-1:0]  a;
    logic [1:0]       mode;
    logic             in_valid;
    logic [OUT_W-1:0] y;
    logic [OUT_W-1:0] y_q;
    logic             out_valid;
`ifdef SIGNEXT_NEGCOUNT_EN
    logic [15:0]      neg_count;
`endif

    modport master (
        output a, mode, in_valid,
`ifdef SIGNEXT_NEGCOUNT_EN
        input  neg_count,
`endif
        input  y, y_q, out_valid
    );

    modport slave (
        input  a, mode, in_valid,
`ifdef SIGNEXT_NEGCOUNT_EN
        output neg_count,
`endif
        output y, y_q, out_valid
    );
endinterface

// File: rtl/sign_ext.sv
// MIPS immediate extender: combinational y plus an ID/EX-style registered copy with valid.
// Optional macro SIGNEXT_NEGCOUNT_EN adds neg_count, a count of negative captures in modes 00/10.
module sign_ext #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    sign_ext_if.slave     bus
);
    localparam int unsigned EXT_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_SEXT = 2'b00;
    localparam logic [1:0] MODE_ZEXT = 2'b01;
    localparam logic [1:0] MODE_BOFS = 2'b10;
    localparam logic [1:0] MODE_LUI  = 2'b11;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] y_c;
    logic [OUT_W-1:0] res_d, res_q;
    logic             vld_d, vld_q;

    // Result selection; each output bit depends only on the a bits that feed it.
    always_comb begin
        sext = {{EXT_W{bus.a[IN_W-1]}}, bus.a};
        y_c  = sext;
        case (bus.mode)
            MODE_SEXT: y_c = sext;
            MODE_ZEXT: y_c = {{EXT_W{1'b0}}, bus.a};
            MODE_BOFS: y_c = {sext[OUT_W-3:0], 2'b00};
            MODE_LUI:  y_c = {bus.a, {EXT_W{1'b0}}};
            default:   y_c = sext;
        endcase
    end

    always_comb begin
        res_d = res_q;
        vld_d = 1'b0;
        if (!rst) begin
            res_d = '0;
        end else if (bus.in_valid) begin
            res_d = y_c;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        res_q <= res_d;
        vld_q <= vld_d;
    end

    assign bus.y         = y_c;
    assign bus.y_q       = res_q;
    assign bus.out_valid = vld_q;

`ifdef SIGNEXT_NEGCOUNT_EN
    logic [15:0] neg_cnt_d, neg_cnt_q;

    // Sign bit only matters as a source sign in the sign-extending modes (mode[0]==0).
    always_comb begin
        neg_cnt_d = neg_cnt_q;
        if (!rst) begin
            neg_cnt_d = '0;
        end else if (bus.in_valid && bus.a[IN_W-1] && !bus.mode[0]) begin
            neg_cnt_d = neg_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        neg_cnt_q <= neg_cnt_d;
    end

    assign bus.neg_count = neg_cnt_q;
`endif
endmodule

// File: tb/tb_sign_ext.sv
// Directed self-checking bench for sign_ext; checks neg_count too when SIGNEXT_NEGCOUNT_EN is defined.
module tb_sign_ext;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    sign_ext_if #(.IN_W(16), .OUT_W(32)) bus ();

    sign_ext #(.IN_W(16), .OUT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic comb(input logic [1:0] m, input logic [15:0] av, input logic [31:0] exp,
                        input string tag);
        bus.mode = m;
        bus.a    = av;
        #1;
        chk(tag, bus.y, exp);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode     = 2'b00;
        bus.a        = 16'h8000;

        // Reset held for two edges with a valid input present
        tick();
        tick();
        chk("rst_yq",    bus.y_q, 32'h0);
        chk("rst_ovld",  32'(bus.out_valid), 32'h0);
        chk("rst_y",     bus.y, 32'hFFFF8000);

        rst = 1'b1;
        tick();
        chk("rel_yq",    bus.y_q, 32'hFFFF8000);
        chk("rel_ovld",  32'(bus.out_valid), 32'h1);

        // Combinational sweep, no clock involvement
        bus.in_valid = 1'b0;
        @(negedge clk);
        comb(2'b00, 16'h0000, 32'h00000000, "sx_0000");
        comb(2'b00, 16'h0001, 32'h00000001, "sx_0001");
        comb(2'b00, 16'h7FFF, 32'h00007FFF, "sx_7fff");
        comb(2'b00, 16'h8000, 32'hFFFF8000, "sx_8000");
        comb(2'b00, 16'h8001, 32'hFFFF8001, "sx_8001");
        comb(2'b00, 16'hFFFF, 32'hFFFFFFFF, "sx_ffff");
        comb(2'b01, 16'h8000, 32'h00008000, "zx_8000");
        comb(2'b11, 16'h1234, 32'h12340000, "lui_1234");
        comb(2'b10, 16'hFFFF, 32'hFFFFFFFC, "bo_ffff");
        comb(2'b10, 16'h4000, 32'h00010000, "bo_4000");
        comb(2'b10, 16'h8001, 32'hFFFE0004, "bo_8001");
        comb(2'b01, 16'hFFFF, 32'h0000FFFF, "zx_ffff");

        // Pipeline burst then idle
        tick();
        bus.mode = 2'b00;
        bus.in_valid = 1'b1;
        bus.a = 16'h0001;
        tick();
        chk("pl1_yq",   bus.y_q, 32'h00000001);
        chk("pl1_ovld", 32'(bus.out_valid), 32'h1);
        bus.a = 16'h8000;
        tick();
        chk("pl2_yq",   bus.y_q, 32'hFFFF8000);
        bus.a = 16'h7FFF;
        tick();
        chk("pl3_yq",   bus.y_q, 32'h00007FFF);
        chk("pl3_ovld", 32'(bus.out_valid), 32'h1);
        bus.in_valid = 1'b0;
        bus.a = 16'h5555;
        tick();
        chk("idle_yq",   bus.y_q, 32'h00007FFF);
        chk("idle_ovld", 32'(bus.out_valid), 32'h0);
        tick();
        chk("hold_yq",   bus.y_q, 32'h00007FFF);

        // Mid-stream reset during a valid burst
        bus.in_valid = 1'b1;
        bus.mode = 2'b11;
        bus.a = 16'h1234;
        tick();
        chk("ms_pre_yq", bus.y_q, 32'h12340000);
        rst = 1'b0;
        bus.mode = 2'b00;
        bus.a = 16'h8001;
        tick();
        chk("ms_rst_yq",   bus.y_q, 32'h0);
        chk("ms_rst_ovld", 32'(bus.out_valid), 32'h0);
        rst = 1'b1;
        bus.a = 16'h0002;
        tick();
        chk("ms_res_yq",   bus.y_q, 32'h00000002);
        chk("ms_res_ovld", 32'(bus.out_valid), 32'h1);

`ifdef SIGNEXT_NEGCOUNT_EN
        rst = 1'b0;
        tick();
        chk("nc_rst0", 32'(bus.neg_count), 32'h0);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.mode = 2'b00;
        bus.a = 16'h8000; tick();
        bus.a = 16'h0001; tick();
        bus.a = 16'hFFFF; tick();
        bus.a = 16'h7FFF; tick();
        bus.a = 16'h8000; tick();
        chk("nc_five", 32'(bus.neg_count), 32'h3);
        // Mode 01 negative and an idle cycle must not count; mode 10 negative does
        bus.mode = 2'b01; bus.a = 16'h8000; tick();
        bus.in_valid = 1'b0; bus.mode = 2'b00; tick();
        bus.in_valid = 1'b1; bus.mode = 2'b10; bus.a = 16'hC000; tick();
        chk("nc_modes", 32'(bus.neg_count), 32'h4);
        rst = 1'b0;
        tick();
        chk("nc_clr", 32'(bus.neg_count), 32'h0);
        rst = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
